// File: rtl/fxm_pkg.sv
// Shared types and constants for the fixed-point multiplier arbiter.
// Saturation constants are used when the design is built with FXM_SAT_EN.
package fxm_pkg;

  localparam int FRACT_BITS = 8;

  typedef logic signed [31:0] q24_8_t;
  typedef logic signed [63:0] q55_8_t;

  // Q24.8 range expressed in the Q55.8 result format.
  localparam q55_8_t Q24_8_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam q55_8_t Q24_8_MIN = 64'shFFFF_FFFF_8000_0000;

endpackage

// File: rtl/fxm_pipe.sv
// Pipelined Q24.8 x Q24.8 multiplier with a tag sideband and a global hold.
// Optional saturation to the Q24.8 range when FXM_SAT_EN is defined.
module fxm_pipe
  import fxm_pkg::*;
#(
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 2,
  parameter int FRACT_BITS  = fxm_pkg::FRACT_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  q24_8_t           in_a,
  input  q24_8_t           in_b,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output q55_8_t           out_p,
  output logic             out_ovf,
  output logic             busy
);

  q55_8_t full;
  q55_8_t shifted;
  q55_8_t res;
  logic   ovf_c;

  logic [PIPE_STAGES-1:0]            v;
  logic [PIPE_STAGES-1:0][TAG_W-1:0] tag;
  logic [PIPE_STAGES-1:0][63:0]      p;
  logic [PIPE_STAGES-1:0]            ovf;

  // The arithmetic is resolved before the first register; later stages only delay.
  always_comb begin
    full    = q55_8_t'(in_a) * q55_8_t'(in_b);
    shifted = full >>> FRACT_BITS;
    res     = shifted;
    ovf_c   = 1'b0;
`ifdef FXM_SAT_EN
    if (shifted > Q24_8_MAX) begin
      res   = Q24_8_MAX;
      ovf_c = 1'b1;
    end else if (shifted < Q24_8_MIN) begin
      res   = Q24_8_MIN;
      ovf_c = 1'b1;
    end
`else
    res   = shifted;
    ovf_c = 1'b0;
`endif
  end

  // Bubbles enter stage 0 whenever the pipe advances without a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v   <= '0;
      tag <= '0;
      p   <= '0;
      ovf <= '0;
    end else if (!hold) begin
      v[0]   <= in_valid;
      tag[0] <= in_tag;
      p[0]   <= res;
      ovf[0] <= ovf_c;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        v[s]   <= v[s-1];
        tag[s] <= tag[s-1];
        p[s]   <= p[s-1];
        ovf[s] <= ovf[s-1];
      end
    end
  end

  assign out_valid = v[PIPE_STAGES-1];
  assign out_tag   = tag[PIPE_STAGES-1];
  assign out_p     = p[PIPE_STAGES-1];
  assign out_ovf   = ovf[PIPE_STAGES-1];
  assign busy      = |v;

endmodule

// File: rtl/fixed_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined Q24.8 multiplier among NUM_REQ requesters.
// Build with FXM_SAT_EN to saturate results to the Q24.8 range and flag overflow.
module fixed_mult_arbiter
  import fxm_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int PIPE_STAGES = 2,
  parameter int FRACT_BITS  = fxm_pkg::FRACT_BITS,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0][31:0] req_a,
  input  logic [NUM_REQ-1:0][31:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic signed [63:0]      rsp_p,
  output logic                    rsp_ovf,
  output logic                    busy
);

  // Handshake: a request transfers on req_valid[i] & req_ready[i]; a response
  // retires on rsp_valid & rsp_ready. A held response freezes the whole pipe.
  logic               stall;
  logic               xfer;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     rr_ptr;
  int                 idx;

  assign stall = rsp_valid & ~rsp_ready;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    xfer      = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!xfer && req_valid[idx]) begin
        xfer       = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
    if (stall || rst) begin
      grant = '0;
      xfer  = 1'b0;
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  fxm_pipe #(
    .PIPE_STAGES (PIPE_STAGES),
    .TAG_W       (IDW),
    .FRACT_BITS  (FRACT_BITS)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall),
    .in_valid  (xfer),
    .in_tag    (grant_idx),
    .in_a      (req_a[grant_idx]),
    .in_b      (req_b[grant_idx]),
    .out_valid (rsp_valid),
    .out_tag   (rsp_id),
    .out_p     (rsp_p),
    .out_ovf   (rsp_ovf),
    .busy      (busy)
  );

endmodule

// File: tb/tb_fixed_mult_arbiter.sv
// Scoreboard bench for fixed_mult_arbiter (default parameters).
// Expected saturation results follow FXM_SAT_EN.
module tb_fixed_mult_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][31:0]   req_a;
  logic [N-1:0][31:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic signed [63:0]   rsp_p;
  logic                 rsp_ovf;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  logic [IDW+64:0] exp_q[$];
  logic [IDW+64:0] mon_exp;
  logic [IDW+64:0] snap;

  logic [63:0] fair_p [N];

  always #5 clk = ~clk;

  fixed_mult_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IDW+64:0] pk(input int id, input logic [63:0] p, input logic ovf);
    return {id[IDW-1:0], p, ovf};
  endfunction

  // Monitor: every retired response must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d p %0h ovf %0b, expected nothing", rsp_id, rsp_p, rsp_ovf);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rsp", {rsp_id, rsp_p, rsp_ovf}, mon_exp);
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] p, input logic ovf);
    bit done;
    done = 1'b0;
    req_a[id] = a;
    req_b[id] = b;
    req_valid[id] = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        chk("send_grant", req_ready, 128'(1) << id);
        exp_q.push_back(pk(id, p, ovf));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no grant for req %0d, expected grant within 50 cycles", id);
    end
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int c = 0; c < 60 && !empty; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) empty = 1'b1;
    end
    checks++;
    if (!empty) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_p"}, {rsp_p}, 0);
    chk({tag, "_rsp_ovf"}, rsp_ovf, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset values, with every requester asking.
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;

    // Single request and its two-cycle latency.
    send(0, 32'h0000_0180, 32'h0000_0200, 64'h0000_0000_0000_0300, 1'b0);
    @(negedge clk);
    chk("lat_early_valid", rsp_valid, 0);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("lat_valid", rsp_valid, 1);
    drain();

    // Negative operand.
    send(0, 32'hFFFF_FE80, 32'h0000_0200, 64'hFFFF_FFFF_FFFF_FD00, 1'b0);
    drain();

    // Exactly the positive bound: never flagged.
    send(0, 32'h7FFF_FFFF, 32'h0000_0100, 64'h0000_0000_7FFF_FFFF, 1'b0);
    drain();

    // Out-of-range results.
`ifdef FXM_SAT_EN
    send(0, 32'h7FFF_FF00, 32'h0000_0200, 64'h0000_0000_7FFF_FFFF, 1'b1);
    send(0, 32'h8000_0000, 32'h0000_0200, 64'hFFFF_FFFF_8000_0000, 1'b1);
`else
    send(0, 32'h7FFF_FF00, 32'h0000_0200, 64'h0000_0000_FFFF_FE00, 1'b0);
    send(0, 32'h8000_0000, 32'h0000_0200, 64'hFFFF_FFFF_0000_0000, 1'b0);
`endif
    drain();

    // A grant to req3 brings the pointer back to 0.
    send(3, 32'h0000_0100, 32'h0000_0100, 64'h0000_0000_0000_0100, 1'b0);
    drain();

    // Fairness: (i+1.0) * 2.0 for requester i.
    fair_p[0] = 64'h200;
    fair_p[1] = 64'h400;
    fair_p[2] = 64'h600;
    fair_p[3] = 64'h800;
    for (int i = 0; i < N; i++) begin
      req_a[i] = 32'((i + 1) * 256);
      req_b[i] = 32'h0000_0200;
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", req_ready, 128'(1) << (k % 4));
      if (|req_ready) exp_q.push_back(pk(k % 4, fair_p[k % 4], 1'b0));
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    drain();

    // Backpressure: rsp_ready low for three cycles mid-stream.
    n = 0;
    req_valid = '1;
    for (int c = 0; c < 40 && n < 8; c++) begin
      rsp_ready = !(c >= 4 && c <= 6);
      @(negedge clk);
      if (!rsp_ready) begin
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_req_ready", req_ready, 0);
        if (c > 4) chk("bp_hold", {rsp_id, rsp_p, rsp_ovf}, snap);
        snap = {rsp_id, rsp_p, rsp_ovf};
      end else begin
        chk("bp_grant", req_ready, 128'(1) << (n % 4));
        if (|req_ready) begin
          exp_q.push_back(pk(n % 4, fair_p[n % 4], 1'b0));
          n++;
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();

    // Reset with two entries in flight; the pointer would otherwise sit at 3.
    rsp_ready = 1'b0;
    req_a[1]  = 32'h0000_0100;
    req_b[1]  = 32'h0000_0100;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("pre_rst_grant1", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_a[2]  = 32'h0000_0100;
    req_b[2]  = 32'h0000_0100;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("pre_rst_grant2", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    chk("pre_rst_busy", busy, 1);
    req_valid = 4'b1100;
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_a[2]  = 32'h0000_0300;
    req_b[2]  = 32'h0000_0280;
    req_a[3]  = 32'hFFFF_FF00;
    req_b[3]  = 32'h0000_0100;
    req_valid = 4'b1100;
    @(negedge clk);
    chk("post_rst_grant2", req_ready, 4'b0100);
    if (|req_ready) exp_q.push_back(pk(2, 64'h0000_0000_0000_0780, 1'b0));
    @(posedge clk);
    #1;
    req_valid = 4'b1000;
    @(negedge clk);
    chk("post_rst_grant3", req_ready, 4'b1000);
    if (|req_ready) exp_q.push_back(pk(3, 64'hFFFF_FFFF_FFFF_FF00, 1'b0));
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
